frogger_collision_game_fsm: RTL and testbench

- Game-level controller that sequences the 8-row collision comparator: qualifies its collision flag, counts lives and levels, and paces the background (traffic) shift rate.
- Sits between the frog/background row registers, the comparator and the display/score logic.
- Issues pulses that reset the frog position and reload the background pattern.

---
 rtl/frogger_collision_game_fsm.sv | 98 +++++++++
 tb/tb_frogger_collision_game_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/frogger_collision_game_fsm.sv
// frogger_collision_game_fsm: qualifies comparator hits, tracks lives/levels and paces background shifts.
// Optional collision-immunity window after each hit is enabled by defining FROGGER_INVULN_EN.
module frogger_collision_game_fsm #(
  parameter int LIVES       = 3,
  parameter int LEVELS      = 4,
  parameter int BASE_PERIOD = 8000000,
  parameter int HIT_HOLD    = 25000000,
  parameter int QUAL_CYCLES = 2
`ifdef FROGGER_INVULN_EN
  , parameter int INVULN_CYCLES = 50000000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       RESET_InLow,
  input  logic       start_In,
  input  logic       collision_In,
  input  logic       frogTop_In,
  output logic [2:0] level_Out,
  output logic [2:0] lives_Out,
  output logic       shiftTick_Out,
  output logic       frogReset_Out,
  output logic       bgLoad_Out,
  output logic       playing_Out,
  output logic       gameOver_Out,
  output logic       win_Out
`ifdef FROGGER_INVULN_EN
  , output logic     invuln_Out
`endif
);
  typedef enum logic [2:0] {IDLE, PLAY, HIT, LEVELUP, GAMEOVER, WIN} stateT;
  stateT state, nextState;
  logic [31:0] shiftCnt, holdCnt, shiftPeriod;
  logic [3:0] qualCnt, qualInc;
  logic colEff, qualHit, wrap, holdDone, startGame, stayPlay, enterPlay;
  assign shiftPeriod = 32'(BASE_PERIOD) >> level_Out;
  assign qualInc = (qualCnt == 4'hF) ? qualCnt : qualCnt + 4'd1;
  assign qualHit = (state == PLAY) && colEff && (qualInc >= 4'(QUAL_CYCLES));
  assign wrap = shiftCnt == shiftPeriod - 32'd1;
  assign holdDone = holdCnt == 32'(HIT_HOLD - 1);
  assign startGame = start_In && (state == IDLE || state == GAMEOVER || state == WIN);
  assign stayPlay = (state == PLAY) && (nextState == PLAY);
  assign enterPlay = (state != PLAY) && (nextState == PLAY);
`ifdef FROGGER_INVULN_EN
  logic [31:0] invCnt, invNext;
  // Window opens only on a return from HIT and drains one count per PLAY cycle.
  assign invNext = (state == HIT && nextState == PLAY) ? 32'(INVULN_CYCLES) :
                   (stayPlay && invCnt != 32'd0) ? invCnt - 32'd1 : 32'd0;
  assign colEff = collision_In && (invCnt == 32'd0);
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow)
    if (!RESET_InLow) begin
      invCnt <= '0;
      invuln_Out <= 1'b0;
    end else begin
      invCnt <= invNext;
      invuln_Out <= invNext != 32'd0;
    end
`else
  assign colEff = collision_In;
`endif
  always_comb begin
    nextState = state;
    case (state)
      IDLE, GAMEOVER, WIN: nextState = start_In ? PLAY : state;
      PLAY:    nextState = qualHit ? HIT : frogTop_In ? LEVELUP : PLAY;
      HIT:     nextState = !holdDone ? HIT : (lives_Out == 3'd0) ? GAMEOVER : PLAY;
      LEVELUP: nextState = (level_Out == 3'(LEVELS - 1)) ? WIN : PLAY;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow)
    if (!RESET_InLow) begin
      state <= IDLE;
      level_Out <= '0;
      lives_Out <= 3'(LIVES);
      shiftCnt <= '0;
      holdCnt <= '0;
      qualCnt <= '0;
      shiftTick_Out <= 1'b0;
      frogReset_Out <= 1'b0;
      bgLoad_Out <= 1'b0;
      playing_Out <= 1'b0;
      gameOver_Out <= 1'b0;
      win_Out <= 1'b0;
    end else begin
      state <= nextState;
      level_Out <= startGame ? 3'd0 : (state == LEVELUP && nextState == PLAY) ? level_Out + 3'd1 : level_Out;
      lives_Out <= startGame ? 3'(LIVES) : (qualHit && lives_Out != 3'd0) ? lives_Out - 3'd1 : lives_Out;
      shiftCnt <= (stayPlay && !wrap) ? shiftCnt + 32'd1 : 32'd0;
      holdCnt <= (state == HIT && nextState == HIT) ? holdCnt + 32'd1 : 32'd0;
      qualCnt <= (stayPlay && colEff) ? qualInc : 4'd0;
      shiftTick_Out <= stayPlay && wrap;
      frogReset_Out <= enterPlay;
      bgLoad_Out <= enterPlay && (state != HIT);
      playing_Out <= nextState == PLAY;
      gameOver_Out <= nextState == GAMEOVER;
      win_Out <= nextState == WIN;
    end
endmodule

// File: tb/tb_frogger_collision_game_fsm.sv
// tb_frogger_collision_game_fsm: directed and random play checked against a game-rule model.
module tb_frogger_collision_game_fsm;
  localparam int LIVES = 3, LEVELS = 4, BASE = 16, HOLD = 4, QUAL = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_UP = 3, M_OVER = 4, M_WIN = 5;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, coll = 1'b0, top = 1'b0;
  logic [2:0] level, lives;
  logic tick, frogRst, bgLoad, playing, over, win;
  int total = 0, bad = 0;
  int mMode, mLevel, mLives, mAge, mRun, mHoldLeft, eTick, eFrog, eBg;
  int ticks;
  always #5 clk = ~clk;
  frogger_collision_game_fsm #(.LIVES(LIVES), .LEVELS(LEVELS), .BASE_PERIOD(BASE),
    .HIT_HOLD(HOLD), .QUAL_CYCLES(QUAL)) dut (
    .CLOCK_50(clk), .RESET_InLow(rst_n), .start_In(start), .collision_In(coll),
    .frogTop_In(top), .level_Out(level), .lives_Out(lives), .shiftTick_Out(tick),
    .frogReset_Out(frogRst), .bgLoad_Out(bgLoad), .playing_Out(playing),
    .gameOver_Out(over), .win_Out(win));
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask
  task automatic modelReset();
    mMode = M_IDLE; mLevel = 0; mLives = LIVES; mAge = 0; mRun = 0; mHoldLeft = 0;
    eTick = 0; eFrog = 0; eBg = 0;
  endtask
  task automatic newGame();
    mMode = M_PLAY; mLevel = 0; mLives = LIVES; mAge = 0; mRun = 0; eFrog = 1; eBg = 1;
  endtask
  // One clock of game rules using the inputs sampled at this edge.
  task automatic modelStep();
    eTick = 0; eFrog = 0; eBg = 0;
    case (mMode)
      M_IDLE, M_OVER, M_WIN: if (start) newGame();
      M_PLAY: begin
        mRun = coll ? mRun + 1 : 0;
        if (mRun >= QUAL) begin
          if (mLives > 0) mLives--;
          mMode = M_HIT; mHoldLeft = HOLD;
        end else if (top) mMode = M_UP;
        else begin
          mAge++;
          if (mAge % (BASE >> mLevel) == 0) eTick = 1;
        end
      end
      M_HIT: begin
        mHoldLeft--;
        if (mHoldLeft == 0) begin
          if (mLives == 0) mMode = M_OVER;
          else begin mMode = M_PLAY; mAge = 0; mRun = 0; eFrog = 1; end
        end
      end
      default: begin
        if (mLevel == LEVELS - 1) mMode = M_WIN;
        else begin mLevel++; mMode = M_PLAY; mAge = 0; mRun = 0; eFrog = 1; eBg = 1; end
      end
    endcase
  endtask
  always @(posedge clk) if (rst_n) begin
    modelStep();
    #1;
    check("level", level, mLevel);
    check("lives", lives, mLives);
    check("tick", tick, eTick);
    check("frogReset", frogRst, eFrog);
    check("bgLoad", bgLoad, eBg);
    check("playing", playing, int'(mMode == M_PLAY));
    check("gameOver", over, int'(mMode == M_OVER));
    check("win", win, int'(mMode == M_WIN));
  end
  task automatic cyc(input logic s, input logic c, input logic t);
    @(negedge clk);
    start = s; coll = c; top = t;
    @(posedge clk);
    #2;
  endtask
  task automatic countTicks(input int n);
    ticks = 0;
    repeat (n) begin cyc(0, 0, 0); ticks += int'(tick); end
  endtask
  task automatic doHit();
    cyc(0, 1, 0); cyc(0, 1, 0);
    repeat (HOLD) cyc(0, 0, 0);
  endtask
  task automatic checkResetVals(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_pulses"}, {tick, frogRst, bgLoad}, 0);
    check({tag, "_status"}, {playing, over, win}, 0);
  endtask
  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1 checkResetVals("reset");
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 0, 0);
    check("start_frog", frogRst, 1); check("start_bg", bgLoad, 1);
    check("start_play", playing, 1); check("start_lives", lives, 3); check("start_level", level, 0);
    countTicks(32);
    check("ticks_l0", ticks, 2);
    cyc(0, 1, 0); cyc(0, 0, 0);
    check("single_coll", playing, 1);
    cyc(0, 1, 0); cyc(0, 1, 0);
    check("hit_play", playing, 0); check("hit_lives", lives, 2);
    ticks = 0;
    repeat (HOLD - 1) begin cyc(0, 0, 0); ticks += int'(tick); end
    check("hit_noticks", ticks, 0); check("hit_held", playing, 0);
    cyc(0, 0, 0);
    check("resume_frog", frogRst, 1); check("resume_bg", bgLoad, 0); check("resume_play", playing, 1);
    for (int lv = 0; lv < LEVELS - 1; lv++) begin
      cyc(0, 0, 1);
      check("levelup_play", playing, 0);
      cyc(0, 0, 0);
      check("levelup_level", level, lv + 1);
      check("levelup_pulses", {frogRst, bgLoad}, 3);
      countTicks(2 * (BASE >> (lv + 1)));
      check("levelup_ticks", ticks, 2);
    end
    cyc(0, 0, 1); cyc(0, 0, 0);
    check("win", win, 1); check("win_play", playing, 0);
    cyc(1, 0, 0);
    check("restart_lives", lives, 3); check("restart_level", level, 0); check("restart_play", playing, 1);
    doHit(); doHit(); doHit();
    check("over", over, 1); check("over_lives", lives, 0);
    cyc(0, 0, 0); cyc(1, 0, 0);
    check("over_restart_lives", lives, 3); check("over_restart_play", playing, 1);
    cyc(0, 1, 0); cyc(0, 1, 1);
    check("hit_wins_play", playing, 0); check("hit_wins_level", level, 0); check("hit_wins_lives", lives, 2);
    repeat (HOLD) cyc(0, 0, 0);
    check("hit_wins_resume", playing, 1);
    repeat (3000) cyc($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 12 && mMode != M_PLAY; i++) cyc(1, 0, 0);
    check("reach_play", mMode, M_PLAY);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 0, 0);
    check("pre_reset_hit", playing, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetVals("async");
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      cyc(0, 0, 0);
      check("post_reset_quiet", {frogRst, bgLoad, playing}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
